// File: rtl/fir_stream_source.sv
// fir_stream_source
//   AXI-stream master that feeds the FIR filter input with a programmable
//   test pattern (impulse, step, ramp, square) at a programmable sample rate.
//   A loaded sample is held until the sink accepts it. A sample tick that
//   arrives while the previous sample is still pending is dropped, and the
//   sticky overrun flag records it.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   enable          run request; low returns to idle once any pending sample completes
//   mode            0 impulse, 1 step, 2 ramp, 3 square
//   amplitude       unsigned pattern amplitude
//   rate_div        sample period minus one, in clk cycles
//   m_axis_tdata    sample data
//   m_axis_tvalid   sample valid
//   m_axis_tready   sink ready
//   sample_index    pattern phase p (accepted samples since start, mod 256)
//   overrun         sticky dropped-tick flag, cleared only by reset
module fir_stream_source #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned RATE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] amplitude,
  input  logic [RATE_W-1:0] rate_div,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [7:0]        sample_index,
  output logic              overrun
);

  localparam int unsigned IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    PRESENT   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [RATE_W-1:0] prescaler;
  logic [RATE_W-1:0] prescaler_next;
  logic [DATA_W-1:0] tdata_next;
  logic              tvalid_next;
  logic [IDX_W-1:0]  index_next;
  logic              overrun_next;

  logic              tick_c;
  logic              handshake_c;
  logic [IDX_W-1:0]  index_inc_c;

  // Pattern value for phase p, using the mode/amplitude present at load time.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] amp,
    input logic [IDX_W-1:0]  p
  );
    logic [DATA_W-1:0] v;
    v = '0;
    case (m)
      2'd0:    v = (p == '0) ? amp : '0;
      2'd1:    v = (p == '0) ? '0 : amp;
      2'd2:    v = DATA_W'(p);
      default: v = p[3] ? '0 : amp;
    endcase
    return v;
  endfunction

  // Compare with >= so a rate_div lowered below the running count ticks at once.
  assign tick_c      = (prescaler >= rate_div);
  assign handshake_c = m_axis_tvalid & m_axis_tready;
  assign index_inc_c = sample_index + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler + RATE_W'(1);
    tdata_next     = m_axis_tdata;
    tvalid_next    = m_axis_tvalid;
    index_next     = sample_index;
    overrun_next   = overrun;

    case (state)
      IDLE: begin
        prescaler_next = '0;
        tvalid_next    = 1'b0;
        if (enable) begin
          state_next = WAIT_TICK;
          index_next = '0;
        end
      end

      WAIT_TICK: begin
        if (tick_c) begin
          prescaler_next = '0;
          tdata_next     = pattern(mode, amplitude, sample_index);
          tvalid_next    = 1'b1;
          state_next     = PRESENT;
        end else if (!enable) begin
          prescaler_next = '0;
          state_next     = IDLE;
        end
      end

      PRESENT: begin
        // Prescaler keeps its period while a sample is held, so ticks stay on a fixed grid.
        if (tick_c) begin
          prescaler_next = '0;
        end
        if (handshake_c) begin
          index_next = index_inc_c;
          if (tick_c && enable) begin
            // Back-to-back: next sample replaces the accepted one, tvalid stays high.
            tdata_next = pattern(mode, amplitude, index_inc_c);
          end else begin
            tvalid_next = 1'b0;
            if (enable) begin
              state_next = WAIT_TICK;
            end else begin
              prescaler_next = '0;
              state_next     = IDLE;
            end
          end
        end else if (tick_c) begin
          overrun_next = 1'b1;
        end
      end

      default: begin
        prescaler_next = '0;
        tvalid_next    = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prescaler     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      sample_index  <= '0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_next;
      prescaler     <= prescaler_next;
      m_axis_tdata  <= tdata_next;
      m_axis_tvalid <= tvalid_next;
      sample_index  <= index_next;
      overrun       <= overrun_next;
    end
  end

endmodule

// File: tb/tb_fir_stream_source.sv
// tb_fir_stream_source
//   Randomized bench for fir_stream_source. The reference treats a running
//   stream as a fixed grid of sample ticks every rate_div+1 cycles after
//   enable. At each tick a new sample is loaded if the slot is free or is
//   being accepted that cycle; otherwise the tick is lost and overrun is set.
//   Directed sequences cover the enable-drop and mid-stream reset cases.
module tb_fir_stream_source;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned RATE_W = 16;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [1:0]        mode;
  logic [DATA_W-1:0] amplitude;
  logic [RATE_W-1:0] rate_div;
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic [7:0]        sample_index;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  fir_stream_source #(.DATA_W(DATA_W), .RATE_W(RATE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .amplitude     (amplitude),
    .rate_div      (rate_div),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .sample_index  (sample_index),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Pattern straight from its definition on the sample count p.
  function automatic int ref_pattern(input int md, input int amp, input int p);
    case (md)
      0:       return (p == 0) ? amp : 0;
      1:       return (p == 0) ? 0 : amp;
      2:       return p % (1 << DATA_W);
      default: return (((p / 8) % 2) == 0) ? amp : 0;
    endcase
  endfunction

  // Run one stream from a fresh reset with enable held high for ncyc cycles.
  task automatic run_seg(input int md, input int amp, input int rd, input int ncyc,
                         input int ready_pct, input int stall_start, input int stall_len,
                         input bit rand_cfg);
    bit ev;
    int ed;
    int ep;
    bit eo;
    bit hs;
    bit tk;
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; tready = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    enable    = 1'b1;
    mode      = 2'(md);
    amplitude = DATA_W'(amp);
    rate_div  = RATE_W'(rd);
    ev = 1'b0; ed = 0; ep = 0; eo = 1'b0;
    // The coming edge (edge 0) starts the stream; ticks fall on multiples of rd+1.
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      check("tvalid", int'(tvalid), int'(ev));
      check("tdata", int'(tdata), ed);
      check("sample_index", int'(sample_index), ep);
      check("overrun", int'(overrun), int'(eo));
      if (n >= stall_start && n < stall_start + stall_len)
        tready = 1'b0;
      else
        tready = ($urandom_range(0, 99) < ready_pct);
      if (rand_cfg && $urandom_range(0, 7) == 0) begin
        mode      = 2'($urandom_range(0, 3));
        amplitude = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      end
      hs = ev && tready;
      tk = (n % (rd + 1)) == 0;
      if (hs) ep = (ep + 1) % 256;
      if (tk) begin
        if (!ev || hs) begin
          ev = 1'b1;
          ed = ref_pattern(int'(mode), int'(amplitude), ep);
        end else begin
          eo = 1'b1;
        end
      end else if (hs) begin
        ev = 1'b0;
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    tready    = 1'b1;
    mode      = 2'd0;
    amplitude = '0;
    rate_div  = '0;

    // Reset dominates a running request.
    repeat (2) @(negedge clk);
    check("rst_tvalid", int'(tvalid), 0);
    check("rst_tdata", int'(tdata), 0);
    check("rst_index", int'(sample_index), 0);
    check("rst_overrun", int'(overrun), 0);

    // Impulse, 4-cycle period, sink always ready.
    run_seg(0, 31, 3, 40, 100, 0, 0, 1'b0);
    // Ramp at full rate across the 63->0 wrap.
    run_seg(2, 0, 0, 140, 100, 0, 0, 1'b0);
    // Square with a 10-cycle stall on the first sample.
    run_seg(3, 20, 2, 60, 100, 4, 10, 1'b0);
    // Step through the 255->0 phase wrap at full rate.
    run_seg(1, 45, 0, 300, 100, 0, 0, 1'b0);
    // Random configurations and backpressure.
    for (int s = 0; s < 8; s++) begin
      int pct;
      case (s % 4)
        0:       pct = 100;
        1:       pct = 80;
        2:       pct = 50;
        default: pct = 20;
      endcase
      run_seg($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 5),
              250, pct, 0, 0, 1'b1);
    end

    // Enable dropped while a sample is stalled.
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; tready = 1'b0;
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; mode = 2'd0; amplitude = DATA_W'(9); rate_div = RATE_W'(1);
    for (int i = 0; i < 20 && !tvalid; i++) @(negedge clk);
    check("ed_valid", int'(tvalid), 1);
    check("ed_data", int'(tdata), 9);
    enable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("ed_hold_valid", int'(tvalid), 1);
      check("ed_hold_data", int'(tdata), 9);
    end
    tready = 1'b1;
    @(negedge clk);
    check("ed_drop", int'(tvalid), 0);
    check("ed_index", int'(sample_index), 1);
    repeat (4) begin
      @(negedge clk);
      check("ed_idle", int'(tvalid), 0);
    end
    enable = 1'b1;
    for (int i = 0; i < 20 && !tvalid; i++) @(negedge clk);
    check("re_valid", int'(tvalid), 1);
    check("re_data", int'(tdata), 9);
    check("re_index", int'(sample_index), 0);

    // Reset in the middle of a handshake with overrun set.
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; tready = 1'b0;
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; mode = 2'd2; rate_div = RATE_W'(0);
    repeat (6) @(negedge clk);
    check("rs_pre_valid", int'(tvalid), 1);
    check("rs_pre_overrun", int'(overrun), 1);
    tready = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("rs_tvalid", int'(tvalid), 0);
    check("rs_tdata", int'(tdata), 0);
    check("rs_index", int'(sample_index), 0);
    check("rs_overrun", int'(overrun), 0);
    reset = 1'b0; enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rs_idle", int'(tvalid), 0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("rs_wait", int'(tvalid), 0);
    @(negedge clk);
    check("rs_restart_valid", int'(tvalid), 1);
    check("rs_restart_data", int'(tdata), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
